// File: rtl/card_match_judge_if.sv
// Bundles the map-load, flip-request and game-status signals of card_match_judge.
// The master drives map and flips; the slave (the judge) returns acks, masks and counters.
`default_nettype none

interface card_match_judge_if #(
  parameter int MOVES_W = 8
);
  logic               map_load_i;
  logic [0:47]        map_in_i;
  logic               flip_req_i;
  logic [3:0]         flip_idx_i;
  logic               flip_ack_o;
  logic               flip_rej_o;
  logic [2:0]         card_val_o;
  logic [15:0]        face_up_o;
  logic [15:0]        matched_o;
  logic               match_pulse_o;
  logic               miss_pulse_o;
  logic [3:0]         pairs_found_o;
  logic [MOVES_W-1:0] moves_o;
  logic               busy_o;
  logic               game_won_o;

  modport master (
    output map_load_i, map_in_i, flip_req_i, flip_idx_i,
    input  flip_ack_o, flip_rej_o, card_val_o, face_up_o, matched_o,
           match_pulse_o, miss_pulse_o, pairs_found_o, moves_o, busy_o, game_won_o
  );

  modport slave (
    input  map_load_i, map_in_i, flip_req_i, flip_idx_i,
    output flip_ack_o, flip_rej_o, card_val_o, face_up_o, matched_o,
           match_pulse_o, miss_pulse_o, pairs_found_o, moves_o, busy_o, game_won_o
  );
endinterface

`default_nettype wire

// File: rtl/card_match_judge.sv
//------------------------------------------------------------------------------
// Module   : card_match_judge
// Brief    : Memory-game judge: latches the card map, pairs flips, scores matches.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module card_match_judge #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int MOVES_W     = 8
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  card_match_judge_if.slave  bus
);

  localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT1   = 3'd1,
    S_WAIT2   = 3'd2,
    S_COMPARE = 3'd3,
    S_SHOW    = 3'd4,
    S_WON     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [0:47]        map_q, map_d;
  logic [15:0]        face_up_q, face_up_d;
  logic [15:0]        matched_q, matched_d;
  logic [3:0]         pairs_q, pairs_d;
  logic [MOVES_W-1:0] moves_q, moves_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         card_val_q, card_val_d;
  logic [3:0]         idx1_q, idx1_d;
  logic [3:0]         idx2_q, idx2_d;
  logic               ack_q, ack_d;
  logic               rej_q, rej_d;
  logic               match_q, match_d;
  logic               miss_q, miss_d;
  logic               flip_ok;

  // Card i occupies map bits [3*i +: 3] of the ascending-range map.
  function automatic logic [2:0] card_of(input logic [0:47] m, input logic [3:0] i);
    logic [5:0] off;
    off = 6'(i) * 6'd3;
    return m[off +: 3];
  endfunction

  assign flip_ok = bus.flip_req_i && ((state_q == S_WAIT1) || (state_q == S_WAIT2))
                   && !face_up_q[bus.flip_idx_i];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      map_q      <= '0;
      face_up_q  <= '0;
      matched_q  <= '0;
      pairs_q    <= '0;
      moves_q    <= '0;
      timer_q    <= '0;
      card_val_q <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      ack_q      <= 1'b0;
      rej_q      <= 1'b0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      face_up_q  <= face_up_d;
      matched_q  <= matched_d;
      pairs_q    <= pairs_d;
      moves_q    <= moves_d;
      timer_q    <= timer_d;
      card_val_q <= card_val_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      ack_q      <= ack_d;
      rej_q      <= rej_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    face_up_d  = face_up_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    moves_d    = moves_q;
    timer_d    = timer_q;
    card_val_d = card_val_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    ack_d      = 1'b0;
    rej_d      = 1'b0;
    match_d    = 1'b0;
    miss_d     = 1'b0;

    if (bus.map_load_i) begin
      // A new map restarts the game from any state and swallows a same-cycle flip.
      state_d    = S_WAIT1;
      map_d      = bus.map_in_i;
      face_up_d  = '0;
      matched_d  = '0;
      pairs_d    = '0;
      moves_d    = '0;
      timer_d    = '0;
      card_val_d = '0;
    end else begin
      if (flip_ok) begin
        ack_d                        = 1'b1;
        face_up_d[bus.flip_idx_i]    = 1'b1;
        card_val_d                   = card_of(map_q, bus.flip_idx_i);
        if (state_q == S_WAIT1) begin
          idx1_d  = bus.flip_idx_i;
          state_d = S_WAIT2;
        end else begin
          idx2_d  = bus.flip_idx_i;
          state_d = S_COMPARE;
        end
      end else if (bus.flip_req_i) begin
        rej_d = 1'b1;
      end

      case (state_q)
        S_COMPARE: begin
          if (moves_q != '1) moves_d = moves_q + MOVES_W'(1);
          if (card_of(map_q, idx1_q) == card_of(map_q, idx2_q)) begin
            match_d           = 1'b1;
            matched_d[idx1_q] = 1'b1;
            matched_d[idx2_q] = 1'b1;
            pairs_d           = pairs_q + 4'd1;
            state_d           = (pairs_q == 4'd7) ? S_WON : S_WAIT1;
          end else begin
            miss_d  = 1'b1;
            timer_d = TIMER_W'(SHOW_CYCLES - 1);
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (timer_q == '0) begin
            face_up_d[idx1_q] = 1'b0;
            face_up_d[idx2_q] = 1'b0;
            state_d           = S_WAIT1;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.flip_ack_o    = ack_q;
  assign bus.flip_rej_o    = rej_q;
  assign bus.card_val_o    = card_val_q;
  assign bus.face_up_o     = face_up_q;
  assign bus.matched_o     = matched_q;
  assign bus.match_pulse_o = match_q;
  assign bus.miss_pulse_o  = miss_q;
  assign bus.pairs_found_o = pairs_q;
  assign bus.moves_o       = moves_q;
  assign bus.busy_o        = (state_q == S_COMPARE) || (state_q == S_SHOW);
  assign bus.game_won_o    = (state_q == S_WON);

endmodule

`default_nettype wire

// File: tb/tb_card_match_judge.sv
//------------------------------------------------------------------------------
// Module   : tb_card_match_judge
// Brief    : Directed and random checks of card_match_judge against a game model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_card_match_judge;

  localparam int SHOW = 4;
  localparam int MW   = 4;
  localparam int MOVES_MAX = (1 << MW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  card_match_judge_if #(.MOVES_W(MW)) bus ();

  card_match_judge #(.SHOW_CYCLES(SHOW), .MOVES_W(MW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Game model: card values, shown/solved sets, cards awaiting judgement.
  int vals[16];
  bit up[16];
  bit mt[16];
  int picks[$];
  bit loaded, won, judged;
  int show_left;
  int e_pairs, e_moves, e_cv;
  bit e_ack, e_rej, e_match, e_miss;
  int mv[16];

  function automatic logic [0:47] pack_map();
    logic [0:47] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[3*i +: 3] = 3'(mv[i]);
    return m;
  endfunction

  function automatic logic [15:0] as_word(input bit b[16]);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin up[i] = 0; mt[i] = 0; end
    picks.delete();
    won = 0; judged = 0; show_left = 0;
    e_pairs = 0; e_moves = 0; e_cv = 0;
  endtask

  task automatic model(input bit ld, input logic [0:47] mp, input bit rq,
                       input logic [3:0] ix, input bit rn);
    bit acc;
    e_ack = 0; e_rej = 0; e_match = 0; e_miss = 0;
    if (!rn) begin
      model_clear();
      loaded = 0;
      for (int i = 0; i < 16; i++) vals[i] = 0;
    end else if (ld) begin
      model_clear();
      loaded = 1;
      for (int i = 0; i < 16; i++) vals[i] = int'(mp[3*i +: 3]);
    end else begin
      acc = loaded && !won && picks.size() < 2 && !up[ix];
      if (picks.size() == 2 && !judged) begin
        e_moves = (e_moves == MOVES_MAX) ? e_moves : e_moves + 1;
        if (vals[picks[0]] == vals[picks[1]]) begin
          e_match = 1;
          mt[picks[0]] = 1; mt[picks[1]] = 1;
          e_pairs++;
          won = (e_pairs == 8);
          picks.delete();
        end else begin
          e_miss = 1; judged = 1; show_left = SHOW - 1;
        end
      end else if (judged) begin
        if (show_left == 0) begin
          up[picks[0]] = 0; up[picks[1]] = 0;
          picks.delete(); judged = 0;
        end else show_left--;
      end
      if (rq) begin
        if (acc) begin
          e_ack = 1; up[ix] = 1; e_cv = vals[ix]; picks.push_back(int'(ix));
        end else e_rej = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("flip_ack",    32'(bus.flip_ack_o),    32'(e_ack));
    chk("flip_rej",    32'(bus.flip_rej_o),    32'(e_rej));
    chk("card_val",    32'(bus.card_val_o),    32'(e_cv));
    chk("face_up",     32'(bus.face_up_o),     32'(as_word(up)));
    chk("matched",     32'(bus.matched_o),     32'(as_word(mt)));
    chk("match_pulse", 32'(bus.match_pulse_o), 32'(e_match));
    chk("miss_pulse",  32'(bus.miss_pulse_o),  32'(e_miss));
    chk("pairs_found", 32'(bus.pairs_found_o), 32'(e_pairs));
    chk("moves",       32'(bus.moves_o),       32'(e_moves));
    chk("busy",        32'(bus.busy_o),        32'(picks.size() == 2));
    chk("game_won",    32'(bus.game_won_o),    32'(won));
  endtask

  task automatic step(input bit ld, input logic [0:47] mp, input bit rq,
                      input logic [3:0] ix, input bit rn = 1'b1);
    resetn         = rn;
    bus.map_load_i = ld;
    bus.map_in_i   = mp;
    bus.flip_req_i = rq;
    bus.flip_idx_i = ix;
    model(ld, mp, rq, ix, rn);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic flip(input logic [3:0] ix);
    step(1'b0, '0, 1'b1, ix);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic shuffle_pairs();
    int a[16];
    int j, t;
    for (int i = 0; i < 16; i++) a[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < 16; i++) mv[i] = a[i];
  endtask

  initial begin
    logic [0:47] base;
    logic [63:0] raw;
    int cnt;
    int v0[16] = '{2, 4, 0, 1, 3, 2, 5, 6, 7, 4, 0, 1, 3, 5, 6, 7};
    for (int i = 0; i < 16; i++) mv[i] = v0[i];
    base = pack_map();
    bus.map_load_i = 0; bus.map_in_i = '0; bus.flip_req_i = 0; bus.flip_idx_i = '0;

    // T1: reset state, flip in IDLE rejected
    step(1'b0, '0, 1'b0, 4'd0, 1'b0);
    step(1'b0, '0, 1'b0, 4'd0, 1'b0);
    flip(4'd3);
    chk("t1_rej", 32'(bus.flip_rej_o), 32'd1);
    idle();
    chk("t1_rej_one_cycle", 32'(bus.flip_rej_o), 32'd0);

    // T2: match 0 and 5
    step(1'b1, base, 1'b0, 4'd0);
    flip(4'd0);
    flip(4'd5);
    chk("t2_card_val", 32'(bus.card_val_o), 32'd2);
    idle();
    chk("t2_match", 32'(bus.match_pulse_o), 32'd1);
    chk("t2_matched", 32'(bus.matched_o), 32'h0021);
    chk("t2_moves", 32'(bus.moves_o), 32'd1);

    // T4: same card twice, matched card
    flip(4'd7);
    flip(4'd7);
    chk("t4_same_rej", 32'(bus.flip_rej_o), 32'd1);
    flip(4'd0);
    chk("t4_matched_rej", 32'(bus.flip_rej_o), 32'd1);
    flip(4'd14);
    idle();

    // T3: miss, face-up held for exactly SHOW cycles
    step(1'b1, base, 1'b0, 4'd0);
    flip(4'd0);
    flip(4'd1);
    idle();
    chk("t3_miss", 32'(bus.miss_pulse_o), 32'd1);
    cnt = (bus.face_up_o == 16'h0003) ? 1 : 0;
    for (int k = 0; k < SHOW; k++) begin
      flip(4'd3);
      if (bus.face_up_o == 16'h0003) cnt++;
    end
    chk("t3_show_len", 32'(cnt), 32'(SHOW));
    chk("t3_cleared", 32'(bus.face_up_o), 32'h0);

    // T5: solve all pairs, win, then reload
    step(1'b1, base, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      if (!mt[i]) begin
        for (int j = i + 1; j < 16; j++) begin
          if (!mt[i] && !mt[j] && vals[j] == vals[i]) begin
            flip(4'(i)); flip(4'(j)); idle();
          end
        end
      end
    end
    chk("t5_pairs", 32'(bus.pairs_found_o), 32'd8);
    chk("t5_won", 32'(bus.game_won_o), 32'd1);
    chk("t5_moves", 32'(bus.moves_o), 32'd8);
    flip(4'd2);
    chk("t5_won_rej", 32'(bus.flip_rej_o), 32'd1);
    step(1'b1, base, 1'b0, 4'd0);
    chk("t5_reload_won", 32'(bus.game_won_o), 32'd0);
    chk("t5_reload_matched", 32'(bus.matched_o), 32'd0);

    // Moves counter saturation via repeated misses
    repeat (20) begin
      flip(4'd0); flip(4'd1);
      repeat (SHOW + 1) idle();
    end
    chk("sat_moves", 32'(bus.moves_o), 32'(MOVES_MAX));

    // T6: load mid-SHOW with simultaneous flip, then reset mid-game
    flip(4'd0); flip(4'd1); idle(); idle();
    step(1'b1, base, 1'b1, 4'd4);
    chk("t6_no_ack", 32'(bus.flip_ack_o), 32'd0);
    chk("t6_no_rej", 32'(bus.flip_rej_o), 32'd0);
    flip(4'd2);
    step(1'b0, '0, 1'b1, 4'd10, 1'b0);
    chk("t6_reset_face", 32'(bus.face_up_o), 32'd0);
    flip(4'd4);
    chk("t6_idle_rej", 32'(bus.flip_rej_o), 32'd1);

    // Random play against the model
    for (int n = 0; n < 3000; n++) begin
      bit ld, rq, rn;
      ld = ($urandom_range(0, 149) == 0) || !loaded;
      rn = ($urandom_range(0, 799) != 0);
      rq = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        raw = {$urandom, $urandom};
        base = raw[47:0];
      end else begin
        shuffle_pairs();
        base = pack_map();
      end
      step(ld, base, rq, 4'($urandom_range(0, 15)), rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
